// File: rtl/orb_pkg.sv
// Shared types and default frame geometry for the orbit-frame packer and reader.
package orb_pkg;
    localparam int ORB_ADDR_W      = 11;
    localparam int ORB_WORD_W      = 12;
    localparam int ORB_FRAME_WORDS = 2048;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} orb_state_e;
endpackage

// File: rtl/orb_bit_timer.sv
// Bit-period divider and per-word bit counter for the serial downlink.
module orb_bit_timer #(
    parameter int WORD_W  = 12,
    parameter int BIT_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bitStrb,
    output logic wordStrb,
    output logic bitEnd,
    output logic lastBit
);
    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_q, bit_d;

    // Counters sit at zero whenever disabled, so the first enabled cycle is bit 0 of a word.
    always_comb begin
        div_d = '0;
        bit_d = '0;
        if (en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + CNT_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
                bit_d = bit_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

    assign bitStrb  = en && (div_q == '0);
    assign wordStrb = bitStrb && (bit_q == '0);
    assign bitEnd   = en && (div_q == DIV_LAST);
    assign lastBit  = bitEnd && (bit_q == BIT_LAST);
endmodule

// File: rtl/orb_reader.sv
// Reads the orbit frame RAM sequentially and serialises each word MSB-first,
// prefetching the next word so the downlink stream has no gaps.
module orb_reader import orb_pkg::*; #(
    parameter int ADDR_W      = ORB_ADDR_W,
    parameter int WORD_W      = ORB_WORD_W,
    parameter int FRAME_WORDS = ORB_FRAME_WORDS,
    parameter int BIT_DIV     = 8,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] rdData,
    output logic [ADDR_W-1:0] rdAddr,
    output logic              rdEn,
    output logic              serOut,
    output logic              bitStrb,
    output logic              wordStrb,
    output logic              busy,
    output logic              frameDone,
    output logic              swOut,
    output logic              overrun
);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W:0]   NUM_WORDS = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic              MULTI     = (FRAME_WORDS > 1);

    orb_state_e        state_q, state_d;
    logic              rdEn_q;
    logic [ADDR_W-1:0] rdAddr_q;
    logic [ADDR_W-1:0] word_q;
    logic              swOut_q;
    logic [RD_LAT-1:0] lat_q;
    logic [RD_LAT:0]   lat_w;
    logic [WORD_W-1:0] sreg_q;
    logic [WORD_W-1:0] pf_q;
    logic              capture, inShift, bitEnd, lastBit, moreWords, morePrefetch;

    // lat_q tracks each rdEn so data is taken exactly RD_LAT cycles later.
    assign lat_w        = {lat_q, rdEn_q};
    assign capture      = lat_q[RD_LAT-1];
    assign inShift      = (state_q == SHIFT);
    assign moreWords    = (word_q != LAST_WORD);
    assign morePrefetch = ({1'b0, word_q} + (ADDR_W+1)'(2)) < NUM_WORDS;

    orb_bit_timer #(
        .WORD_W  (WORD_W),
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (inShift),
        .bitStrb  (bitStrb),
        .wordStrb (wordStrb),
        .bitEnd   (bitEnd),
        .lastBit  (lastBit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (capture) state_d = SHIFT;
            SHIFT:   if (lastBit && !moreWords) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdEn_q   <= 1'b0;
            rdAddr_q <= '0;
            word_q   <= '0;
            swOut_q  <= 1'b0;
            lat_q    <= '0;
        end else begin
            rdEn_q <= 1'b0;
            lat_q  <= lat_w[RD_LAT-1:0];
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rdEn_q   <= 1'b1;
                        rdAddr_q <= '0;
                        word_q   <= '0;
                    end
                end
                FETCH: begin
                    if (capture && MULTI) begin
                        rdEn_q   <= 1'b1;
                        rdAddr_q <= rdAddr_q + ADDR_W'(1);
                    end
                end
                SHIFT: begin
                    if (lastBit) begin
                        if (moreWords) begin
                            word_q <= word_q + ADDR_W'(1);
                            if (morePrefetch) begin
                                rdEn_q   <= 1'b1;
                                rdAddr_q <= rdAddr_q + ADDR_W'(1);
                            end
                        end else begin
                            swOut_q <= ~swOut_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The first word goes straight into the shifter; later words come from the prefetch register.
    always_ff @(posedge clk) begin
        if (capture) pf_q <= rdData;
        if ((state_q == FETCH) && capture) begin
            sreg_q <= rdData;
        end else if (inShift) begin
            if (lastBit && moreWords) sreg_q <= pf_q;
            else if (bitEnd)          sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
        end
    end

    assign rdEn      = rdEn_q;
    assign rdAddr    = rdAddr_q;
    assign serOut    = inShift && sreg_q[WORD_W-1];
    assign busy      = (state_q == FETCH) || inShift;
    assign frameDone = (state_q == DONE);
    assign swOut     = swOut_q;
    assign overrun   = start && busy;
endmodule

// File: tb/tb_orb_reader.sv
// Three reader configurations driven by directed and random starts/resets,
// checked every cycle against a frame-timeline model.
module tb_orb_reader;
    localparam int WB = 24;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        checking = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        rst_v [3] = '{1'b1, 1'b1, 1'b1};
    logic        start_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [11:0] rdData_v [3];
    logic [10:0] rdAddr_v [3];
    logic        rdEn_v [3];
    logic        serOut_v [3];
    logic        bitStrb_v [3];
    logic        wordStrb_v [3];
    logic        busy_v [3];
    logic        frameDone_v [3];
    logic        swOut_v [3];
    logic        overrun_v [3];

    logic [11:0] ram [3][2048];

    int          t0 [3] = '{-1, -1, -1};
    logic        sw_m [3] = '{1'b0, 1'b0, 1'b0};
    logic [10:0] addr_m [3] = '{11'd0, 11'd0, 11'd0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int FW  = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        localparam int LAT = (g == 1) ? 3 : 1;
        logic [11:0] pipe [LAT];

        always @(posedge clk) begin
            pipe[0] <= rdEn_v[g] ? ram[g][rdAddr_v[g]] : 12'($urandom);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rdData_v[g] = pipe[LAT-1];

        orb_reader #(
            .ADDR_W      (11),
            .WORD_W      (12),
            .FRAME_WORDS (FW),
            .BIT_DIV     (2),
            .RD_LAT      (LAT)
        ) dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .start     (start_v[g]),
            .rdData    (rdData_v[g]),
            .rdAddr    (rdAddr_v[g]),
            .rdEn      (rdEn_v[g]),
            .serOut    (serOut_v[g]),
            .bitStrb   (bitStrb_v[g]),
            .wordStrb  (wordStrb_v[g]),
            .busy      (busy_v[g]),
            .frameDone (frameDone_v[g]),
            .swOut     (swOut_v[g]),
            .overrun   (overrun_v[g])
        );
    end

    function automatic int fw_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, g, cyc, act, exp);
        end
    endtask

    // Expected outputs follow from the start cycle alone: fixed fetch latency,
    // then FW words of 24 cycles each, then one frameDone cycle.
    task automatic model_step(input int g);
        int   c, first, done, n, w, b;
        logic e_busy, e_rden, e_ser, e_bit, e_word, e_done, e_ovr;
        c = cyc;
        first = 0; done = 0;
        e_busy = 0; e_rden = 0; e_ser = 0; e_bit = 0; e_word = 0; e_done = 0; e_ovr = 0;
        if (rst_v[g]) begin
            t0[g] = -1;
            sw_m[g] = 1'b0;
            addr_m[g] = '0;
        end else if (t0[g] >= 0) begin
            first = t0[g] + lat_of(g) + 2;
            done  = first + fw_of(g) * WB;
            e_busy = (c > t0[g]) && (c < done);
            if (c == t0[g] + 1) begin
                e_rden = 1'b1;
                addr_m[g] = '0;
            end else if (c >= first && c < done - WB && ((c - first) % WB) == 0) begin
                e_rden = 1'b1;
                addr_m[g] = 11'((c - first) / WB + 1);
            end
            if (c >= first && c < done) begin
                n = c - first;
                w = n / WB;
                b = 11 - (n % WB) / 2;
                e_ser  = ram[g][w][b];
                e_bit  = (n % 2) == 0;
                e_word = (n % WB) == 0;
            end
            if (c == done) begin
                e_done = 1'b1;
                sw_m[g] = ~sw_m[g];
            end
            e_ovr = start_v[g] && e_busy;
        end
        chk("busy", g, 16'(busy_v[g]), 16'(e_busy));
        chk("rdEn", g, 16'(rdEn_v[g]), 16'(e_rden));
        chk("rdAddr", g, 16'(rdAddr_v[g]), 16'(addr_m[g]));
        chk("serOut", g, 16'(serOut_v[g]), 16'(e_ser));
        chk("bitStrb", g, 16'(bitStrb_v[g]), 16'(e_bit));
        chk("wordStrb", g, 16'(wordStrb_v[g]), 16'(e_word));
        chk("frameDone", g, 16'(frameDone_v[g]), 16'(e_done));
        chk("swOut", g, 16'(swOut_v[g]), 16'(sw_m[g]));
        chk("overrun", g, 16'(overrun_v[g]), 16'(e_ovr));
        if (!rst_v[g] && start_v[g] && (t0[g] < 0 || c > done)) t0[g] = c;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int g = 0; g < 3; g++) model_step(g);
            // Hand-derived timeline points (first frame starts at cycle 5).
            case (cyc)
                2:   begin chk("lit_rst_busy", 0, 16'(busy_v[0]), 16'd0);
                           chk("lit_rst_addr", 0, 16'(rdAddr_v[0]), 16'd0); end
                6:   begin chk("lit_rdEn0", 0, 16'(rdEn_v[0]), 16'd1);
                           chk("lit_addr0", 0, 16'(rdAddr_v[0]), 16'd0);
                           chk("lit_rdEn_fw1", 2, 16'(rdEn_v[2]), 16'd1); end
                8:   begin chk("lit_rdEn1", 0, 16'(rdEn_v[0]), 16'd1);
                           chk("lit_addr1", 0, 16'(rdAddr_v[0]), 16'd1);
                           chk("lit_ser_b11", 0, 16'(serOut_v[0]), 16'd1);
                           chk("lit_wstrb0", 0, 16'(wordStrb_v[0]), 16'd1);
                           chk("lit_ser_fw1", 2, 16'(serOut_v[2]), 16'd1);
                           chk("lit_rdEn_fw1_none", 2, 16'(rdEn_v[2]), 16'd0); end
                9:   begin chk("lit_ser_fw1_b", 2, 16'(serOut_v[2]), 16'd1);
                           chk("lit_lat3_nobit", 1, 16'(bitStrb_v[1]), 16'd0); end
                10:  begin chk("lit_ser_b10", 0, 16'(serOut_v[0]), 16'd0);
                           chk("lit_ser_fw1_lo", 2, 16'(serOut_v[2]), 16'd0);
                           chk("lit_lat3_first", 1, 16'(wordStrb_v[1]), 16'd1); end
                12:  chk("lit_ser_b9", 0, 16'(serOut_v[0]), 16'd1);
                32:  begin chk("lit_rdEn2", 0, 16'(rdEn_v[0]), 16'd1);
                           chk("lit_addr2", 0, 16'(rdAddr_v[0]), 16'd2);
                           chk("lit_wstrb1", 0, 16'(wordStrb_v[0]), 16'd1);
                           chk("lit_ser_w1", 0, 16'(serOut_v[0]), 16'd0);
                           chk("lit_done_fw1", 2, 16'(frameDone_v[2]), 16'd1); end
                56:  chk("lit_addr3", 0, 16'(rdAddr_v[0]), 16'd3);
                58:  chk("lit_done_lat3", 1, 16'(frameDone_v[1]), 16'd1);
                103: chk("lit_sw_before", 0, 16'(swOut_v[0]), 16'd0);
                104: begin chk("lit_done1", 0, 16'(frameDone_v[0]), 16'd1);
                           chk("lit_sw1", 0, 16'(swOut_v[0]), 16'd1); end
                115: chk("lit_ovr1", 0, 16'(overrun_v[0]), 16'd1);
                155: chk("lit_ovr2", 0, 16'(overrun_v[0]), 16'd1);
                204: begin chk("lit_done2", 0, 16'(frameDone_v[0]), 16'd1);
                           chk("lit_sw2", 0, 16'(swOut_v[0]), 16'd0); end
                359: begin chk("lit_pre_rst_sw", 0, 16'(swOut_v[0]), 16'd1);
                           chk("lit_pre_rst_addr", 0, 16'(rdAddr_v[0]), 16'd2); end
                360: begin chk("lit_rst_sw", 0, 16'(swOut_v[0]), 16'd0);
                           chk("lit_rst_busy_mid", 0, 16'(busy_v[0]), 16'd0); end
                367: begin chk("lit_restart_rdEn", 0, 16'(rdEn_v[0]), 16'd1);
                           chk("lit_restart_addr", 0, 16'(rdAddr_v[0]), 16'd0); end
                default: ;
            endcase
        end
    end

    task automatic goto(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic randomize_ram();
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 4; i++) ram[g][i] = 12'($urandom);
    endtask

    task automatic random_phase(input int from, input int to);
        for (int c = from; c < to; c++) begin
            goto(c);
            for (int g = 0; g < 3; g++) begin
                start_v[g] = ($urandom_range(0, 15) == 0);
                rst_v[g]   = ($urandom_range(0, 999) == 0);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++)
            for (int i = 0; i < 2048; i++) ram[g][i] = 12'h000;
        ram[0][0] = 12'hA5C; ram[0][1] = 12'h123; ram[0][2] = 12'hFFF; ram[0][3] = 12'h000;
        ram[1][0] = 12'h5A3; ram[1][1] = 12'hC0F;
        ram[2][0] = 12'h800;
        checking = 1'b1;

        goto(3);   rst_v = '{1'b0, 1'b0, 1'b0};
        goto(5);   start_v = '{1'b1, 1'b1, 1'b1};
        goto(6);   start_v = '{1'b0, 1'b0, 1'b0};
        goto(105); start_v[0] = 1'b1;
        goto(106); start_v[0] = 1'b0;
        goto(115); start_v[0] = 1'b1;
        goto(116); start_v[0] = 1'b0;
        goto(155); start_v[0] = 1'b1;
        goto(156); start_v[0] = 1'b0;
        goto(215); start_v[0] = 1'b1;
        goto(216); start_v[0] = 1'b0;
        goto(320); start_v[0] = 1'b1;
        goto(321); start_v[0] = 1'b0;
        goto(360); rst_v[0] = 1'b1;
        goto(363); rst_v[0] = 1'b0;
        goto(366); start_v[0] = 1'b1;
        goto(367); start_v[0] = 1'b0;

        goto(470); randomize_ram();
        random_phase(471, 1970);
        goto(1970);
        rst_v = '{1'b1, 1'b1, 1'b1};
        start_v = '{1'b0, 1'b0, 1'b0};
        randomize_ram();
        goto(1973); rst_v = '{1'b0, 1'b0, 1'b0};
        random_phase(1974, 3470);
        goto(3470);
        rst_v = '{1'b0, 1'b0, 1'b0};
        start_v = '{1'b0, 1'b0, 1'b0};
        goto(3480);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/orb_reader.md
Name: orb_reader

Overview:
- Read-side counterpart of the orbit-frame packer.
- The packer fills a 2048×12 frame RAM through WE/WrAddr/orbWord. This block reads that RAM sequentially from address 0 and serialises each 12-bit word MSB-first onto the downlink line.
- At frame end it toggles a buffer-select line, so the packer's SW input swaps ping-pong halves.
- Sits between the frame RAM read port and the transmitter output stage.

Parameters:
ADDR_W, 11, RAM address width
WORD_W, 12, RAM word width / bits per serial word
FRAME_WORDS, 2048, words per frame, range 1..2**ADDR_W
BIT_DIV, 8, clk cycles per serial bit, ≥2
RD_LAT, 1, RAM read latency in cycles (1..3); WORD_W*BIT_DIV > RD_LAT+1 required

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  frame request; sampled only in IDLE
rdData  in  WORD_W  RAM read data, valid RD_LAT cycles after the rdEn cycle
rdAddr  out  ADDR_W  RAM read address (registered)
rdEn  out  1  RAM read enable, one-cycle pulse per word
serOut  out  1  serial data, MSB first
bitStrb  out  1  high on first cycle of every bit period
wordStrb  out  1  high on first cycle of bit 11 of every word
busy  out  1  high from start acceptance until frameDone
frameDone  out  1  one-cycle pulse after the last bit of the frame
swOut  out  1  buffer select; toggles with frameDone
overrun  out  1  one-cycle pulse when start is high while busy

Behaviour:
- Reset (async, rst=1): all outputs 0, rdAddr=0, swOut=0, state IDLE, counters cleared. Reset mid-frame aborts immediately; no frameDone is issued.
- States:
  - IDLE: start=1 → FETCH; busy=1 from the next cycle.
  - FETCH: rdEn=1, rdAddr=0 for one cycle; wait RD_LAT cycles; capture rdData into the prefetch register → SHIFT.
  - SHIFT: shift register loaded from prefetch. serOut=sreg[11]. Each bit is held BIT_DIV cycles, then the register shifts left.
    - Same cycle as the load, if more words remain: rdEn=1, rdAddr+1. Prefetch captures RD_LAT cycles later.
    - After 12 bits: if words remain, reload from prefetch with no gap; otherwise → DONE.
  - DONE: frameDone=1, swOut toggles, busy=0, serOut=0 → IDLE. start in that cycle is ignored; it is accepted from the next cycle.
- Timing (start sampled at cycle 0):
  - rdEn/rdAddr=0 at cycle 1.
  - First bit, bitStrb and wordStrb at cycle RD_LAT+2.
  - frameDone at cycle RD_LAT+2+FRAME_WORDS*WORD_W*BIT_DIV.
- Stream is continuous: exactly WORD_W*BIT_DIV cycles between consecutive wordStrb pulses.
- rdAddr counts 0..FRAME_WORDS-1. It is never issued beyond that, and it holds its last value until the next start, which restarts from 0.
- rdData is captured only on the cycle exactly RD_LAT cycles after rdEn; other values are ignored.
- start while busy: ignored, overrun pulses each such cycle, stream undisturbed.
- Outside SHIFT: serOut=0, bitStrb=0, wordStrb=0.
- FRAME_WORDS=1: no prefetch rdEn is issued in SHIFT.

Decomposition:
- Shared package holds:
  - state enum {IDLE, FETCH, SHIFT, DONE};
  - default constants ORB_ADDR_W=11, ORB_WORD_W=12, ORB_FRAME_WORDS=2048, which the packer also uses.
- One natural sub-module: orb_bit_timer. It provides the BIT_DIV divider plus the 12-bit counter and outputs bitStrb, wordStrb, and lastBit.
- The top keeps the FSM, address counter, read-latency pipe, prefetch register and shift register.

Test Plan:
1. FRAME_WORDS=4, BIT_DIV=2, RD_LAT=1; RAM holds 0xA5C,0x123,0xFFF,0x000; start at cycle 0:
   - rdEn at cycles 1,3,27,51 with addrs 0,1,2,3;
   - serOut = 101001011100 then 000100100011…;
   - frameDone at cycle 99; swOut 0→1.
2. Back-to-back frames, start asserted again at cycle 100 → second frame identical; swOut 1→0 at cycle 199.
3. start pulses at cycles 10 and 50 during frame → overrun pulses at 10 and 50; serial stream and frameDone cycle unchanged.
4. rst asserted at cycle 40 mid-frame → all outputs 0 the same cycle; no frameDone; swOut=0. New start after release → frame starts at address 0.
5. RD_LAT=3, BIT_DIV=2, FRAME_WORDS=2 → first bit at cycle 5, frameDone at cycle 53, no gap between words.
6. FRAME_WORDS=1, data 0x800 → exactly one rdEn; serOut high for 2 cycles then low for 22; frameDone at cycle 27.
